// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the digit-serial packed-BCD
//               adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // One packed BCD digit
  typedef logic [3:0] bcd_digit_t;

  // Control states of the serial engine (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest legal decimal digit and the decimal-adjust correction
  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adder
// Description : Combinational single-digit BCD adder with +6 decimal
//               correction. Illegal digits are not trapped; the same rule
//               produces a deterministic result for them.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       c_in,
  output bcd_digit_t digit,
  output logic       c_out
);

  logic [4:0] w_raw;
  logic [3:0] w_adj;

  // Binary add, then decimal-adjust when the sum leaves the 0..9 range
  always_comb begin
    w_raw = {1'b0, a_d} + {1'b0, b_d} + {4'd0, c_in};
    // Only the low nibble of (raw + 6) is ever kept
    w_adj = w_raw[3:0] + BCD_CORR;
    if (w_raw > {1'b0, BCD_MAX}) begin
      digit = w_adj;
      c_out = 1'b1;
    end else begin
      digit = w_raw[3:0];
      c_out = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd_addsub_serial
// Description : Digit-serial packed-BCD adder/subtractor. Accepts one operand
//               set in IDLE, processes one digit per clock (LSD first) in
//               RUN, and holds the result in DONE until it is taken.
//               Subtraction uses nine's complement of b with an inverted
//               borrow as the initial carry.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int c_width = 4 * DIGITS;
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

  state_t               r_state;
  logic [c_width-1:0]   r_a;
  logic [c_width-1:0]   r_b;
  logic [c_width-1:0]   r_res;
  logic                 r_carry;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_inv;
  logic [c_width-1:0]   r_sum;
  logic                 r_cout;
  logic                 r_invalid;

  logic [c_width-1:0]   w_b_eff;
  logic                 w_in_inv;
  bcd_digit_t           w_digit;
  logic                 w_c;
  logic [c_width-1:0]   w_res_next;

  // Operand conditioning at capture: nine's complement of b for subtract,
  // and detection of any out-of-range digit in a or the raw b
  always_comb begin
    w_b_eff  = b;
    w_in_inv = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > BCD_MAX) || (b[4*i +: 4] > BCD_MAX)) begin
        w_in_inv = 1'b1;
      end
      if (sub) begin
        w_b_eff[4*i +: 4] = BCD_MAX - b[4*i +: 4];
      end
    end
  end

  // Single shared digit adder; operands are shifted so digit 0 is always current
  bcd_digit_adder u_digit_adder (
    .a_d   (r_a[3:0]),
    .b_d   (r_b[3:0]),
    .c_in  (r_carry),
    .digit (w_digit),
    .c_out (w_c)
  );

  // New digits enter at the top so that after DIGITS shifts digit 0 sits at [3:0]
  generate
    if (DIGITS == 1) begin : g_res_single
      assign w_res_next = w_digit;
    end else begin : g_res_multi
      assign w_res_next = {w_digit, r_res[c_width-1:4]};
    end
  endgenerate

  // Control FSM plus serial datapath and output holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_inv     <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= sub ? ~cin : cin;
            r_idx   <= '0;
            r_inv   <= w_in_inv;
            r_res   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_c;
          r_res   <= w_res_next;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == c_last_idx) begin
            r_sum     <= w_res_next;
            r_cout    <= w_c;
            r_invalid <= r_inv;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake flags come straight from state, so no input-to-output paths
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign invalid   = r_invalid;

endmodule
`default_nettype wire

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Digit-serial, parametrised packed-BCD adder/subtractor. Generalises the fixed 4-digit combinational BCD adder to DIGITS digits, adds a subtract mode and invalid-digit detection, and processes one digit per clock behind valid/ready handshakes. It sits in the decimal arithmetic datapath where area matters more than latency.

## Interface
- DIGITS, 4: number of BCD digits per operand, ≥1; operand width is 4*DIGITS bits.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set offered.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  4*DIGITS  packed BCD operand, digit 0 in bits [3:0].
- b  in  4*DIGITS  packed BCD operand.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes result.
- sum  out  4*DIGITS  packed BCD result, modulo 10^DIGITS.
- cout  out  1  add: decimal carry out; sub: 1 = no borrow (a ≥ b+cin), 0 = borrow, sum is ten's complement.
- invalid  out  1  some digit of a or b exceeded 9 in this operation.

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b (b replaced per digit by 9−b_d, 4-bit wrap, when sub=1), carry register = cin (add) or ~cin (sub), digit index=0, invalid accumulator = OR of (digit>9) over all a and raw b digits; go RUN.
- RUN: each cycle process digit at index i, LSD first: s = a_i + b'_i + c (5-bit); if s>9 then digit=(s+6)[3:0], c=1 else digit=s[3:0], c=0. Write digit into result shift register, increment i. After digit DIGITS−1, load sum, cout (=final c), invalid into output registers; go DONE.
- DONE: out_valid=1; sum/cout/invalid stable. On out_ready, go IDLE. in_valid ignored in RUN and DONE.
- Invalid digits are not trapped: the correction rule above still gives a deterministic result, flagged by invalid.
- Outputs sum/cout/invalid hold last result until the next completion overwrites them.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, invalid=0; internal registers 0.
- rst_n low at any time (including mid-RUN or DONE) immediately aborts; the operation is discarded and no out_valid is issued.
- Latency: out_valid rises DIGITS clock edges after the accepting edge (DIGITS=4 → 4 edges).
- Throughput: one operation per DIGITS+2 cycles minimum (accept, DIGITS RUN cycles, DONE handshake); in_ready returns the cycle after the out_valid&&out_ready edge.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Structure
- Package bcd_pkg: bcd_digit_t (4-bit), state enum {IDLE, RUN, DONE}, localparam BCD_MAX=9, BCD_CORR=6.
- Sub-module bcd_digit_adder: combinational one-digit add with +6 correction (a_d, b_d, c_in → digit, c_out); instantiated once and reused each RUN cycle.
- Digit index counter width $clog2(DIGITS) with a minimum of 1.

## Test plan
- DIGITS=4, add a=9999 b=0001 cin=0 → sum=0000 cout=1 invalid=0; out_valid exactly 4 edges after accept.
- Add a=1234 b=5678 cin=1 → sum=6913 cout=0.
- Sub a=5000 b=1234 cin=0 → sum=3766 cout=1; sub a=0000 b=0001 cin=0 → sum=9999 cout=0.
- Hold out_ready=0 for 3 cycles in DONE with in_valid=1 → sum/cout stable, in_ready=0, no new capture; after out_ready, in_ready=1 the next cycle.
- Add a=00A0 b=0000 cin=0 → sum=0100 cout=0 invalid=1.
- Assert rst_n=0 during the 2nd RUN cycle → all outputs return to reset values, in_ready=1, out_valid never asserts for the aborted operation.
